dmem_responder: RTL
===================

# dmem_responder

Data-memory responder on the memory-stage RAM port: it receives requests on the `ram_*` request/response port (byte address, read/write enables, 64-bit bit-mask, write data) and returns read data one cycle later. It holds a word-organised array of `DEPTH` 64-bit entries. Masked writes merge into that array. Out-of-range accesses are flagged. After every reset, an init sequencer zeroes the whole array before the block accepts traffic. It sits between the memory stage and the data RAM storage, as the slave end of that interface.

## Interface
Parameters:
- `DEPTH`, 4096: number of 64-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte address of word 0; aligned to `DEPTH*8`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ram_addr` in 64: byte address; bits [2:0] ignored, word index = `(ram_addr - BASE_ADDR) >> 3`.
- `ram_r_ena` in 1: read request this cycle.
- `ram_w_ena` in 1: write request this cycle.
- `ram_w_mask` in 64: per-bit write mask; 1 = bit written.
- `ram_w_data` in 64: write data, lane-aligned by requester.
- `ram_r_data` out 64: read response, registered.
- `init_busy` out 1: high while array is being zeroed; requests ignored.
- `oob_err` out 1: registered one-cycle pulse for an out-of-range access.

## Operation
- FSM states:
  - `INIT`: entered on reset; a word counter sweeps 0..`DEPTH-1`, writing 64'h0 to one word per cycle.
  - `READY`: entered the cycle after the counter writes `DEPTH-1`; the block stays in `READY` until reset.
- In `INIT`:
  - `ram_r_ena` and `ram_w_ena` are ignored; no array write from the port.
  - `ram_r_data` holds 0; `oob_err` stays 0.
- In range: `BASE_ADDR ≤ ram_addr < BASE_ADDR + DEPTH*8`, computed on the full 64 bits, with no wrap.
- Write, in `READY`, in range, `ram_w_ena=1`: `mem[idx] <= (mem[idx] & ~ram_w_mask) | (ram_w_data & ram_w_mask)`. A zero mask is a legal no-op.
- Read, in `READY`, in range, `ram_r_ena=1`: `ram_r_data <= mem[idx]`.
- Read and write to the same word in the same cycle is write-first: `ram_r_data` gets the merged post-write value.
- `ram_r_ena=0`: `ram_r_data` holds its previous value.
- Out of range with either enable set:
  - No array update.
  - `ram_r_data <= 0` if `ram_r_ena=1`.
  - `oob_err <= 1` for one cycle.
- Both enables low: no state change except the counter while in `INIT`.

## Timing
- Reset values (asynchronous):
  - state = `INIT`, counter = 0, `init_busy` = 1.
  - `ram_r_data` = 0, `oob_err` = 0.
- Array contents are undefined until `INIT` completes.
- Init takes exactly `DEPTH` cycles after `rst_n` rises. `init_busy` falls on the edge that enters `READY`.
- Read latency is 1: data for a request sampled at edge N is visible after edge N, valid for the whole cycle N+1.
- Write latency is 1: written data is visible to a read issued in the next cycle, and to a same-cycle read through write-first.
- Back-to-back requests are accepted every cycle; there is no backpressure other than `init_busy`.
- Reset asserted mid-`INIT` or mid-traffic:
  - Immediate return to `INIT` with counter 0.
  - Any in-flight write is lost.
  - The sweep restarts from word 0.

## Structure
- Shared package `dmem_pkg` holds:
  - FSM state enum `dmem_state_t` {`INIT`, `READY`}.
  - `REG_W`=64 and `ZERO_WORD`.
  - `WORD_OFF`=3 (log2 of bytes per word).
- Sub-module `dmem_array`: the `DEPTH`×64 storage with one write port (index, mask, data) and one synchronous write-first read port. This keeps the storage replaceable by a vendor macro.
- The top level holds the FSM, init counter, range check, and `oob_err` register.

## Test plan
- Reset release, `DEPTH=16`:
  - `init_busy` stays 1 for 16 cycles, then 0.
  - A read of `BASE_ADDR+8*k` for every k returns 64'h0.
- Masked write with mask 64'h0000_0000_0000_FF00, data 64'h0000_0000_0000_AB00 to `BASE_ADDR+0x10`, then a read of the same address → 64'h0000_0000_0000_AB00.
- A full-mask write of 64'hFFFF_FFFF_FFFF_FFFF, then a byte write of 0x12 at byte lane 3 (mask 64'h0000_0000_FF00_0000) → read returns 64'hFFFF_FFFF_12FF_FFFF.
- Same-cycle read and write to the same word, full mask, data 64'hDEAD_BEEF_0123_4567 → `ram_r_data` equals 64'hDEAD_BEEF_0123_4567 on the next cycle.
- Out-of-range accesses:
  - Read at `BASE_ADDR-8` → `oob_err` pulses 1 for one cycle, `ram_r_data`=0.
  - Write at `BASE_ADDR+DEPTH*8` → `oob_err` pulses, and a scan of the array shows no change.
- `rst_n` pulsed low at init cycle 5, and again after a write of 64'h55 to word 2 → `init_busy` restarts a full `DEPTH`-cycle sweep, and word 2 then reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned REG_W    = 64;
  localparam int unsigned WORD_OFF = 3;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    INIT,
    READY
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: one bit-masked write port and one synchronous
// write-first read port. No reset on the storage or the read register.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             w_ena,
  input  logic [AW-1:0]    w_idx,
  input  logic [REG_W-1:0] w_mask,
  input  logic [REG_W-1:0] w_data,
  input  logic             r_ena,
  input  logic [AW-1:0]    r_idx,
  output logic [REG_W-1:0] r_data
);

  logic [REG_W-1:0] mem [DEPTH];
  logic [REG_W-1:0] merged;

  // Masked merge of the incoming write into the currently stored word.
  always_comb begin
    merged = (mem[w_idx] & ~w_mask) | (w_data & w_mask);
  end

  // Storage update and write-first registered read.
  always_ff @(posedge clk) begin
    if (w_ena) begin
      mem[w_idx] <= merged;
    end
    if (r_ena) begin
      r_data <= (w_ena && (w_idx == r_idx)) ? merged : mem[r_idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: init sweep FSM, address range check, OOB flag,
// and the request path into the storage array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ram_addr,
  input  logic        ram_r_ena,
  input  logic        ram_w_ena,
  input  logic [63:0] ram_w_mask,
  input  logic [63:0] ram_w_data,
  output logic [63:0] ram_r_data,
  output logic        init_busy,
  output logic        oob_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [REG_W:0] SPAN = (REG_W + 1)'(DEPTH) << WORD_OFF;

  dmem_state_t      state;
  logic [AW-1:0]    cnt;
  logic             rd_zero;

  logic [REG_W-1:0] offset;
  logic             in_range;
  logic [AW-1:0]    idx;
  logic             ready;
  logic             wr_ok;
  logic             rd_ok;

  logic             arr_w_ena;
  logic [AW-1:0]    arr_w_idx;
  logic [REG_W-1:0] arr_w_mask;
  logic [REG_W-1:0] arr_w_data;
  logic [REG_W-1:0] arr_r_data;

  // Range check on the full address width; the offset is widened so the
  // upper bound can never wrap.
  always_comb begin
    offset   = ram_addr - BASE_ADDR;
    in_range = (ram_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    idx      = offset[WORD_OFF +: AW];
    ready    = (state == READY);
    wr_ok    = ready && ram_w_ena && in_range;
    rd_ok    = ready && ram_r_ena && in_range;
  end

  // Array write port: the init sweep owns it until READY.
  always_comb begin
    arr_w_ena  = wr_ok;
    arr_w_idx  = idx;
    arr_w_mask = ram_w_mask;
    arr_w_data = ram_w_data;
    if (state == INIT) begin
      arr_w_ena  = 1'b1;
      arr_w_idx  = cnt;
      arr_w_mask = '1;
      arr_w_data = ZERO_WORD;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .w_ena  (arr_w_ena),
    .w_idx  (arr_w_idx),
    .w_mask (arr_w_mask),
    .w_data (arr_w_data),
    .r_ena  (rd_ok),
    .r_idx  (idx),
    .r_data (arr_r_data)
  );

  // Init/ready FSM with registered busy, OOB pulse and read-zeroing flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      oob_err   <= 1'b0;
      rd_zero   <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          oob_err <= 1'b0;
          cnt     <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          oob_err <= (ram_r_ena || ram_w_ena) && !in_range;
          if (ram_r_ena) begin
            rd_zero <= !in_range;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // The storage read register has no reset and is left untouched by an
  // out-of-range read, so a held flag forces the response to zero instead.
  always_comb begin
    ram_r_data = rd_zero ? ZERO_WORD : arr_r_data;
  end

endmodule
